// File: rtl/noc_pkt_merge_n.sv
// noc_pkt_merge_n: N-input packet-atomic merger onto one Avalon-ST NoC port.
// Per-input skid FIFOs, round-robin or fixed-priority grant, stray-beat drop.
module noc_pkt_merge_n #(
    parameter int N_IN       = 2,
    parameter int DATA_WIDTH = 64,
    parameter int SKID_DEPTH = 4,
    parameter int ARB_MODE   = 0,
    localparam int EW = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1,
    localparam int SW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_IN-1:0]            in_valid,
    input  logic [N_IN-1:0]            in_sop,
    input  logic [N_IN-1:0]            in_eop,
    input  logic [N_IN-1:0]            in_error,
    input  logic [N_IN*EW-1:0]         in_empty,
    input  logic [N_IN*DATA_WIDTH-1:0] in_data,
    output logic [N_IN-1:0]            in_ready,
    output logic                       out_valid,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic                       out_error,
    output logic [EW-1:0]              out_empty,
    output logic [DATA_WIDTH-1:0]      out_data,
    input  logic                       out_ready,
    output logic [SW-1:0]              o_src,
    output logic                       o_drop,
    output logic [15:0]                o_drop_count
);

    localparam int AW    = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int BW    = DATA_WIDTH + EW + 3;
    localparam int B_SOP = BW - 1;
    localparam int B_EOP = BW - 2;
    localparam int B_ERR = BW - 3;
    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_LOCK   = 1'b1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(SKID_DEPTH);

    logic [BW-1:0]   mem    [N_IN][SKID_DEPTH];
    logic [AW-1:0]   wr_ptr [N_IN];
    logic [AW-1:0]   rd_ptr [N_IN];
    logic [AW:0]     cnt    [N_IN];
    logic [BW-1:0]   head   [N_IN];
    logic [N_IN-1:0] push, pop, nonempty, full, hsop, elig, sop2;
    logic [N_IN-1:0] stray, drop_sel, own_pop, cand;
    logic [0:0]      state;
    logic [SW-1:0]   owner, last_grant, base, win;
    logic            locked, xfer, xfer_eop;
    logic [BW-1:0]   ohead;

    // First requester after base (RR, base itself last) or lowest index (FP)
    function automatic logic [SW-1:0] pick(input logic [N_IN-1:0] req,
                                           input logic [SW-1:0]   b);
        logic [SW-1:0] w;
        int            idx;
        w = '0;
        for (int k = N_IN; k >= 1; k--) begin
            idx = int'(b) + k;
            if (idx >= N_IN) idx = idx - N_IN;
            if (ARB_MODE != 0) idx = k - 1;
            if (req[idx]) w = SW'(idx);
        end
        return w;
    endfunction

    // Per-input head view and status flags
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            head[i]     = mem[i][rd_ptr[i]];
            nonempty[i] = (cnt[i] != '0);
            full[i]     = (cnt[i] == FULL_CNT);
            hsop[i]     = head[i][B_SOP];
            elig[i]     = nonempty[i] && hsop[i];
            sop2[i]     = (cnt[i] > (AW + 1)'(1)) &&
                          mem[i][AW'(rd_ptr[i] + 1'b1)][B_SOP];
        end
    end

    assign locked    = (state == S_LOCK);
    assign ohead     = head[owner];
    assign out_valid = locked && nonempty[owner];
    assign xfer      = out_valid && out_ready;
    assign xfer_eop  = xfer && ohead[B_EOP];
    assign out_sop   = out_valid && ohead[B_SOP];
    assign out_eop   = out_valid && ohead[B_EOP];
    assign out_error = out_valid && ohead[B_ERR];
    assign out_empty = out_valid ? ohead[DATA_WIDTH +: EW] : '0;
    assign out_data  = out_valid ? ohead[DATA_WIDTH-1:0] : '0;
    assign o_src     = locked ? owner : '0;
    assign in_ready  = ~full & {N_IN{~reset}};
    assign push      = in_valid & in_ready;

    // Pops: owner on transfer, plus the lowest non-owner stray head
    always_comb begin
        stray   = nonempty & ~hsop;
        own_pop = '0;
        if (locked) begin
            stray[owner]   = 1'b0;
            own_pop[owner] = xfer;
        end
        drop_sel = stray & (~stray + 1'b1);
        pop      = own_pop | drop_sel;
    end

    // Grant candidates; on an eop transfer the owner's popped head is gone
    always_comb begin
        cand = elig;
        base = last_grant;
        if (locked) begin
            cand[owner] = sop2[owner];
            base        = owner;
        end
        win = pick(cand, base);
    end

    // Beat storage, written on accepted input beats
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_IN; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= {in_sop[i], in_eop[i], in_error[i],
                                      in_empty[i*EW +: EW],
                                      in_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                cnt[i] <= cnt[i] + (AW + 1)'(push[i]) - (AW + 1)'(pop[i]);
            end
        end
    end

    // Packet-atomic ownership: regrant only on an accepted eop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            owner      <= '0;
            last_grant <= SW'(N_IN - 1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (|cand) begin
                        state <= S_LOCK;
                        owner <= win;
                    end
                end
                S_LOCK: begin
                    if (xfer_eop) begin
                        last_grant <= owner;
                        if (|cand) owner <= win;
                        else       state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Drop pulse and saturating drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_drop       <= 1'b0;
            o_drop_count <= '0;
        end else begin
            o_drop <= |drop_sel;
            if ((|drop_sel) && (o_drop_count != 16'hFFFF))
                o_drop_count <= o_drop_count + 16'd1;
        end
    end

endmodule

// File: doc/noc_pkt_merge_n.md
# noc_pkt_merge_n

Parametrised N-input packet merger feeding a single Avalon-ST NoC injection port in the packet-parser datapath. Each input has its own SKID_DEPTH-entry buffer, so upstream stages never lose beats when the NoC drops ready. Arbitration is packet-atomic: once a packet starts on the output, it runs to eop before any other input is granted. The arbiter is either round-robin or fixed-priority, and back-to-back packets go out with no idle cycle. Replaces the two-input header/payload merger and generalises its payload-out flag to a source index.

## Interface
Parameters:
- N_IN, 2: number of input streams (2..8).
- DATA_WIDTH, 64: beat width in bits (multiple of 8).
- SKID_DEPTH, 4: per-input buffer depth (power of two, ≥2).
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports (EW = $clog2(DATA_WIDTH/8); SW = max(1,$clog2(N_IN))):
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  N_IN  per-input beat valid.
- in_sop  in  N_IN  start of packet.
- in_eop  in  N_IN  end of packet.
- in_error  in  N_IN  error flag, carried with the beat.
- in_empty  in  N_IN*EW  empty bytes on the eop beat; input i occupies slice [i*EW +: EW].
- in_data  in  N_IN*DATA_WIDTH  beat data; input i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  N_IN  per-input ready.
- out_valid, out_sop, out_eop, out_error  out  1 each  NoC-side beat and flags.
- out_empty  out  EW  NoC-side empty count.
- out_data  out  DATA_WIDTH  NoC-side data.
- out_ready  in  1  NoC ready.
- o_src  out  SW  index of the input currently owning the output; valid while out_valid=1.
- o_drop  out  1  one-cycle pulse: a stray (non-sop) head beat was discarded.
- o_drop_count  out  16  saturating count of discarded beats.

## Operation
- Per-input buffer: a FIFO holding {sop, eop, error, empty, data}.
  - in_ready[i] = !full[i]; it is registered-state derived and does not depend on out_ready.
  - A beat is written when in_valid[i] && in_ready[i].
  - A beat is popped on an output transfer (out_valid && out_ready) from the owner, or on a drop.
  - Simultaneous push and pop when full is not possible, because ready is already low. Simultaneous push and pop otherwise leaves the count unchanged.
- Eligible[i]: buffer i is non-empty and its head has sop=1.
- FSM, two states:
  - IDLE: out_valid=0. If any input is eligible, pick a winner and go to LOCKED with owner=winner.
  - LOCKED: out_* = owner's head beat; out_valid = owner non-empty; o_src = owner.
    - An accepted beat with eop=1 sets last_grant=owner.
    - In the same cycle, if any other input (or the owner itself) is eligible, pick a winner, counting the popped head as gone. Stay in LOCKED with the new owner; this is back-to-back with no bubble.
    - If nothing is eligible, go to IDLE.
- Winner selection:
  - Round-robin: first eligible index scanning last_grant+1, last_grant+2, … with modulo N_IN wrap.
  - Fixed priority: lowest eligible index.
- Stray beat: a non-owner head with sop=0 is popped in that cycle, at most one per cycle, lowest index first. This asserts o_drop and increments o_drop_count, which saturates at 0xFFFF.
- The owner's head is never dropped. A beat with sop=1 inside a locked packet is forwarded unchanged; the downstream depacketiser handles it.
- Reset (asynchronous, any time, including mid-packet):
  - Buffers empty; FSM in IDLE; last_grant = N_IN-1, so input 0 wins first under RR.
  - out_valid=0, out_sop/eop/error/empty/data=0, o_src=0, o_drop=0, o_drop_count=0.
  - in_ready=0 while reset is high.
  - A partial packet is discarded; no eop is generated.

## Timing
- Input to output latency: 2 cycles minimum. Beat written at edge k; IDLE grant at edge k+1; out_valid high after edge k+1, transfer at edge k+2.
- Sustained throughput: 1 beat/cycle from the owner when its buffer is never empty; zero idle cycles between consecutive packets.
- out_* may change only after an accepted transfer or an FSM transition.
  - While out_valid=1 && out_ready=0, all out_* and o_src hold stable.
- in_ready[i] rises the cycle after a pop from a full buffer.

## Test plan
- N_IN=2, RR: input 0 sends 3-beat packet A, input 1 sends 2-beat packet B, both at cycle 0, out_ready=1. Expect A0,A1,A2,B0,B1 contiguously; o_src=0,0,0,1,1; first out_valid 2 cycles after input.
- N_IN=4, RR, all inputs continuously sending 1-beat packets. Expect grant order 0,1,2,3,0,…; no gaps; each input gets 25% ±1 packet over 400 cycles.
- ARB_MODE=1, inputs 1 and 3 always eligible. Expect only input 1 served.
- out_ready toggled 1,0,0,1 mid-packet, SKID_DEPTH=4, each input sending 8-beat packets.
  - in_ready[i] falls after 4 buffered beats.
  - No beat lost or duplicated; out_* stable while stalled.
- Input 2 presents a head with sop=0 and data 0xDEAD while input 0 owns the output. Expect o_drop pulse, o_drop_count 0→1, 0xDEAD never on the output.
- Reset asserted mid-packet, asynchronous to clk. Expect out_valid=0 and in_ready=0 immediately. After release, input 0 wins the first grant and no stale beats appear.
